// File: rtl/bch_pkg.sv
// Shared types and defaults for the BCH channel pipeline: FSM states,
// default generator polynomial, error cap and the position-width helper.
package bch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENCODE,
    INJECT,
    SYNDROME,
    LOCATE,
    DONE
  } state_t;

  localparam logic [5:0]  DEF_GEN_POLY = 6'b100101;
  localparam int unsigned DEF_MAX_ERR  = 4;

  // Bits needed to address any of n codeword positions.
  function automatic int unsigned pos_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bch_lfsr.sv
// Free-running 16-bit maximal-length Galois LFSR (x^16+x^14+x^13+x^11+1)
// used as the random error-position source.
module bch_lfsr (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] rnd
);

  always_ff @(posedge clk) begin
    if (rst) begin
      rnd <= seed;
    end else begin
      rnd <= {1'b0, rnd[15:1]} ^ (rnd[0] ? 16'hB400 : 16'h0000);
    end
  end

endmodule

// File: rtl/bch_channel_pipe.sv
// Serial systematic encoder, error-injecting channel, syndrome computer and
// single-bit locator for one K-bit word at a time, with valid/ready handshakes.
module bch_channel_pipe
  import bch_pkg::*;
#(
  parameter int unsigned K         = 8,
  parameter int unsigned M         = 5,
  parameter logic [M:0]  GEN_POLY  = DEF_GEN_POLY,
  parameter int unsigned MAX_ERR   = DEF_MAX_ERR,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [K-1:0]   in_data,
  input  logic [K+M-1:0] in_err_mask,
  input  logic           cfg_encode,
  input  logic           cfg_inject,
  input  logic           cfg_correct,
  input  logic [3:0]     cfg_num_err,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [K-1:0]   out_data,
  output logic [K+M-1:0] out_codeword,
  output logic [M-1:0]   out_syndrome,
  output logic           out_err_detected,
  output logic           out_corrected,
  output logic [3:0]     out_err_count
);

  localparam int unsigned N  = K + M;
  localparam int unsigned PW = pos_width(N);
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [M-1:0] GEN_LOW = GEN_POLY[M-1:0];

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [K-1:0]    data;
  logic [N-1:0]    mask;
  logic            enc;
  logic            inj;
  logic            cor;
  logic [3:0]      tgt;
  logic [N-1:0]    sh;
  logic [M-1:0]    rem;
  logic [N-1:0]    cw;
  logic [N-1:0]    inj_seen;
  logic [3:0]      err_cnt;
  logic [M-1:0]    syn;
  logic            det;
  logic            corr;
  logic [M-1:0]    r;

  logic [15:0]     rnd;
  logic [PW-1:0]   pos;
  logic            unused_rnd;
  logic [N-1:0]    pos_bit_c;
  logic            pos_ok_c;
  logic [N-1:0]    loc_bit_c;
  logic [M-1:0]    enc_rem_c;
  logic [M-1:0]    syn_rem_c;
  logic [M-1:0]    r_next_c;
  logic [N-1:0]    enc_cw_c;

  bch_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .rnd  (rnd)
  );

  assign pos        = rnd[PW-1:0];
  assign unused_rnd = ^rnd[15:PW];

  function automatic logic [3:0] target_count(input logic [3:0] req);
    int unsigned t;
    t = 32'(req);
    if (t > MAX_ERR) t = MAX_ERR;
    if (t > N) t = N;
    return 4'(t);
  endfunction

  // Per-cycle arithmetic: one division step for encode/syndrome, one x-multiply for locate.
  always_comb begin
    pos_bit_c = N'(1) << pos;
    pos_ok_c  = (32'(pos) < N) && ((pos_bit_c & inj_seen) == '0);
    loc_bit_c = N'(1) << cnt;
    enc_rem_c = {rem[M-2:0], 1'b0} ^ ((sh[N-1] ^ rem[M-1]) ? GEN_LOW : '0);
    syn_rem_c = {rem[M-2:0], sh[N-1]} ^ (rem[M-1] ? GEN_LOW : '0);
    r_next_c  = {r[M-2:0], 1'b0} ^ (r[M-1] ? GEN_LOW : '0);
    enc_cw_c  = {data, (enc ? rem : M'(0))} ^ mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      in_ready         <= 1'b0;
      cnt              <= '0;
      data             <= '0;
      mask             <= '0;
      enc              <= 1'b0;
      inj              <= 1'b0;
      cor              <= 1'b0;
      tgt              <= '0;
      sh               <= '0;
      rem              <= '0;
      cw               <= '0;
      inj_seen         <= '0;
      err_cnt          <= '0;
      syn              <= '0;
      det              <= 1'b0;
      corr             <= 1'b0;
      r                <= '0;
      out_valid        <= 1'b0;
      out_data         <= '0;
      out_codeword     <= '0;
      out_syndrome     <= '0;
      out_err_detected <= 1'b0;
      out_corrected    <= 1'b0;
      out_err_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            state    <= ENCODE;
            cnt      <= '0;
            data     <= in_data;
            mask     <= in_err_mask;
            enc      <= cfg_encode;
            inj      <= cfg_inject;
            cor      <= cfg_correct;
            tgt      <= target_count(cfg_num_err);
            sh       <= {in_data, M'(0)};
            rem      <= '0;
            inj_seen <= '0;
            err_cnt  <= '0;
            syn      <= '0;
            det      <= 1'b0;
            corr     <= 1'b0;
          end else begin
            in_ready <= 1'b1;
          end
        end

        // K shift cycles, then one cycle to assemble the codeword and apply the mask.
        ENCODE: begin
          if (cnt == CW'(K)) begin
            cw  <= enc_cw_c;
            sh  <= enc_cw_c;
            rem <= '0;
            cnt <= '0;
            if (inj && (tgt != 4'd0)) state <= INJECT;
            else if (enc)             state <= SYNDROME;
            else                      state <= DONE;
          end else begin
            rem <= enc_rem_c;
            sh  <= sh << 1;
            cnt <= cnt + CW'(1);
          end
        end

        INJECT: begin
          if (pos_ok_c) begin
            cw       <= cw ^ pos_bit_c;
            sh       <= cw ^ pos_bit_c;
            inj_seen <= inj_seen | pos_bit_c;
            err_cnt  <= err_cnt + 4'd1;
            if ((err_cnt + 4'd1) == tgt) state <= enc ? SYNDROME : DONE;
          end
        end

        SYNDROME: begin
          rem <= syn_rem_c;
          sh  <= sh << 1;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            syn   <= syn_rem_c;
            det   <= |syn_rem_c;
            cnt   <= '0;
            r     <= M'(1);
            state <= ((|syn_rem_c) && cor) ? LOCATE : DONE;
          end
        end

        // r tracks x^cnt mod g; a match pins the single-bit error position.
        LOCATE: begin
          if (r == syn) begin
            cw    <= cw ^ loc_bit_c;
            corr  <= 1'b1;
            state <= DONE;
          end else if (cnt == CW'(N - 1)) begin
            state <= DONE;
          end else begin
            r   <= r_next_c;
            cnt <= cnt + CW'(1);
          end
        end

        DONE: begin
          if (!out_valid) begin
            out_valid        <= 1'b1;
            out_data         <= cw[N-1:M];
            out_codeword     <= cw;
            out_syndrome     <= syn;
            out_err_detected <= det;
            out_corrected    <= corr;
            out_err_count    <= err_cnt;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bch_channel_pipe.sv
// Self-checking bench for bch_channel_pipe: directed spec scenarios followed by
// randomized words checked against a polynomial long-division reference model.
module tb_bch_channel_pipe;

  localparam int unsigned K = 8;
  localparam int unsigned M = 5;
  localparam int unsigned N = 13;
  localparam logic [5:0]  GP = 6'b100101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [12:0] in_err_mask = '0;
  logic        cfg_encode = 1'b0;
  logic        cfg_inject = 1'b0;
  logic        cfg_correct = 1'b0;
  logic [3:0]  cfg_num_err = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [12:0] out_codeword;
  logic [4:0]  out_syndrome;
  logic        out_err_detected;
  logic        out_corrected;
  logic [3:0]  out_err_count;

  int n_cmp  = 0;
  int n_fail = 0;

  bch_channel_pipe #(
    .K(K), .M(M), .GEN_POLY(GP), .MAX_ERR(4), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_err_mask(in_err_mask),
    .cfg_encode(cfg_encode), .cfg_inject(cfg_inject), .cfg_correct(cfg_correct),
    .cfg_num_err(cfg_num_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_codeword(out_codeword), .out_syndrome(out_syndrome),
    .out_err_detected(out_err_detected), .out_corrected(out_corrected),
    .out_err_count(out_err_count)
  );

  always #5 clk = ~clk;

  // Remainder of v(x) mod g(x) by textbook long division.
  function automatic logic [4:0] poly_mod(input logic [12:0] v);
    logic [12:0] t;
    logic [12:0] g;
    t = v;
    g = 13'(GP);
    for (int b = 12; b >= 5; b--) begin
      if (t[b]) t = t ^ (g << (b - 5));
    end
    return t[4:0];
  endfunction

  function automatic logic [12:0] clean_cw(input logic [7:0] d);
    return {d, poly_mod({d, 5'b0})};
  endfunction

  task automatic check(input string tag, input string fld,
                       input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_word(input string tag, input logic [7:0] d, input logic [12:0] mk,
                            input logic e, input logic i, input logic c, input logic [3:0] ne);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    check(tag, "in_ready_pre", 32'(in_ready), 32'd1);
    in_data     = d;
    in_err_mask = mk;
    cfg_encode  = e;
    cfg_inject  = i;
    cfg_correct = c;
    cfg_num_err = ne;
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
  endtask

  task automatic wait_out(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 300) begin
      tick();
      lat++;
    end
    check(tag, "out_valid_seen", 32'(out_valid), 32'd1);
  endtask

  task automatic finish_word(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check(tag, "valid_after_hs", 32'(out_valid), 32'd0);
    check(tag, "ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  // Full expected result for a word with no random injection.
  task automatic check_model(input string tag, input logic [7:0] d, input logic [12:0] mk,
                             input logic e, input logic c, input int lat);
    logic [12:0] rx;
    logic [12:0] cw;
    logic [4:0]  syn;
    logic        det;
    logic        corr;
    int          loc;
    rx   = {d, (e ? poly_mod({d, 5'b0}) : 5'b0)} ^ mk;
    syn  = e ? poly_mod(rx) : 5'b0;
    det  = (syn != 5'b0);
    cw   = rx;
    corr = 1'b0;
    if (e && det && c) begin
      loc = -1;
      for (int i = 0; i < 13; i++) begin
        if (loc < 0 && poly_mod(13'(1) << i) == syn) loc = i;
      end
      if (loc >= 0) begin
        cw   = rx ^ (13'(1) << loc);
        corr = 1'b1;
      end
    end
    check(tag, "codeword", 32'(out_codeword), 32'(cw));
    check(tag, "data", 32'(out_data), 32'(cw[12:5]));
    check(tag, "syndrome", 32'(out_syndrome), 32'(syn));
    check(tag, "detected", 32'(out_err_detected), 32'(det));
    check(tag, "corrected", 32'(out_corrected), 32'(corr));
    check(tag, "err_count", 32'(out_err_count), 32'd0);
    if (!(e && det && c)) check(tag, "latency", 32'(lat), e ? 32'(K + N + 2) : 32'(K + 2));
  endtask

  // Random injection: positions unknown, but count and consistency are fixed.
  task automatic check_inject(input string tag, input logic [7:0] d, input logic [12:0] mk,
                              input logic e, input int tgt);
    logic [4:0] syn;
    syn = e ? poly_mod(out_codeword) : 5'b0;
    check(tag, "err_count", 32'(out_err_count), 32'(tgt));
    check(tag, "flips", 32'($countones(out_codeword ^ clean_cw(d) ^ mk ^
                              (e ? 13'h0 : 13'(poly_mod({d, 5'b0}))))), 32'(tgt));
    check(tag, "syndrome", 32'(out_syndrome), 32'(syn));
    check(tag, "detected", 32'(out_err_detected), 32'(syn != 5'b0));
    check(tag, "corrected", 32'(out_corrected), 32'd0);
    check(tag, "data", 32'(out_data), 32'(out_codeword[12:5]));
  endtask

  initial begin
    int lat;
    int seen;

    // Reset state
    tick();
    tick();
    check("reset", "in_ready", 32'(in_ready), 32'd0);
    check("reset", "out_valid", 32'(out_valid), 32'd0);
    check("reset", "codeword", 32'(out_codeword), 32'd0);
    check("reset", "data", 32'(out_data), 32'd0);
    check("reset", "syndrome", 32'(out_syndrome), 32'd0);
    check("reset", "flags", 32'({out_err_detected, out_corrected, out_err_count}), 32'd0);
    rst = 1'b0;
    tick();
    check("reset", "in_ready_after", 32'(in_ready), 32'd1);

    // Clean word
    start_word("clean", 8'hAA, 13'h0, 1'b1, 1'b0, 1'b0, 4'd0);
    wait_out("clean", lat);
    check("clean", "codeword_const", 32'(out_codeword), 32'h1558);
    check_model("clean", 8'hAA, 13'h0, 1'b1, 1'b0, lat);
    finish_word("clean");

    // Single deterministic error, corrected
    start_word("single", 8'hAA, 13'h0008, 1'b1, 1'b0, 1'b1, 4'd0);
    wait_out("single", lat);
    check("single", "syndrome_const", 32'(out_syndrome), 32'h08);
    check("single", "codeword_const", 32'(out_codeword), 32'h1558);
    check_model("single", 8'hAA, 13'h0008, 1'b1, 1'b1, lat);
    finish_word("single");

    // Random injection capped at MAX_ERR
    start_word("inject", 8'hAA, 13'h0, 1'b1, 1'b1, 1'b0, 4'd9);
    wait_out("inject", lat);
    check("inject", "popcount_const", 32'($countones(out_codeword ^ 13'h1558)), 32'd4);
    check_inject("inject", 8'hAA, 13'h0, 1'b1, 4);
    finish_word("inject");

    // Backpressure in DONE
    start_word("bp", 8'hAA, 13'h0, 1'b1, 1'b0, 1'b0, 4'd0);
    wait_out("bp", lat);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_codeword !== 13'h1558 ||
          out_syndrome !== 5'd0 || out_err_detected !== 1'b0) seen++;
    end
    check("bp", "unstable_cycles", 32'(seen), 32'd0);
    finish_word("bp");

    // Reset while in SYNDROME
    start_word("midrst", 8'hAA, 13'h0008, 1'b1, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < int'(K) + 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst", "in_ready", 32'(in_ready), 32'd0);
    check("midrst", "codeword", 32'(out_codeword), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) seen++;
      tick();
    end
    check("midrst", "valid_rises", 32'(seen), 32'd0);
    start_word("after_rst", 8'h3C, 13'h0, 1'b1, 1'b0, 1'b1, 4'd0);
    wait_out("after_rst", lat);
    check("after_rst", "syndrome_const", 32'(out_syndrome), 32'd0);
    check_model("after_rst", 8'h3C, 13'h0, 1'b1, 1'b1, lat);
    finish_word("after_rst");

    // Bypass
    start_word("bypass", 8'h5A, 13'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    wait_out("bypass", lat);
    check("bypass", "codeword_const", 32'(out_codeword), 32'h0B40);
    check_model("bypass", 8'h5A, 13'h0, 1'b0, 1'b0, lat);
    finish_word("bypass");

    // Randomized words
    for (int w = 0; w < 24; w++) begin
      logic [7:0]  d;
      logic [12:0] mk;
      logic        e;
      logic        i;
      logic        c;
      logic [3:0]  ne;
      int          tgt;
      d  = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       mk = 13'h0;
        1:       mk = 13'(1) << $urandom_range(0, 12);
        2:       mk = 13'($urandom);
        default: mk = (13'(1) << $urandom_range(0, 12)) | (13'(1) << $urandom_range(0, 12));
      endcase
      e   = ($urandom_range(0, 3) != 0);
      i   = ($urandom_range(0, 2) == 0);
      c   = i ? 1'b0 : 1'($urandom_range(0, 1));
      ne  = 4'($urandom);
      tgt = i ? ((int'(ne) > 4) ? 4 : int'(ne)) : 0;
      start_word("rand", d, mk, e, i, c, ne);
      wait_out("rand", lat);
      if (tgt == 0) check_model("rand", d, mk, e, c, lat);
      else          check_inject("rand", d, mk, e, tgt);
      finish_word("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
